// File: rtl/cache_controller.sv
// cache_controller: 4-way set-associative cache controller with a write-through,
// no-write-allocate policy. Tags and valid bits live here; line data lives in an
// external 4-way data store driven through the cache_* ports.
module cache_controller #(
    parameter int bitsDirect  = 10,
    parameter int sizeBitLine = 64,
    parameter int bitsTag     = 6
) (
    input  logic                          clk,
    input  logic                          gen_reset,
    input  logic                          cpu_req,
    input  logic                          cpu_we,
    input  logic [bitsTag+bitsDirect-1:0] cpu_addr,
    input  logic [sizeBitLine-1:0]        cpu_wdata,
    output logic                          cpu_ready,
    output logic                          cpu_hit,
    output logic [sizeBitLine-1:0]        cpu_rdata,
    output logic                          ram_req,
    output logic                          ram_we,
    output logic [bitsTag+bitsDirect-1:0] ram_addr,
    output logic [sizeBitLine-1:0]        ram_wdata,
    input  logic                          ram_ack,
    input  logic [sizeBitLine-1:0]        ram_rdata,
    output logic [3:0]                    cache_we,
    output logic [1:0]                    cache_we_cpu,
    output logic                          cache_we_ram,
    output logic                          cache_re,
    output logic [bitsDirect-1:0]         cache_addr,
    output logic [sizeBitLine-1:0]        cache_din,
    input  logic [sizeBitLine-1:0]        cache_dout1,
    input  logic [sizeBitLine-1:0]        cache_dout2,
    input  logic [sizeBitLine-1:0]        cache_dout3,
    input  logic [sizeBitLine-1:0]        cache_dout4
);

    localparam int AW   = bitsTag + bitsDirect;
    localparam int SETS = 1 << bitsDirect;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        WRITE_RAM,
        REFILL,
        FILL
    } state_t;

    state_t                  state_q, state_d;
    logic [AW-1:0]           addr_q, addr_d;
    logic                    we_q, we_d;
    logic [sizeBitLine-1:0]  wdata_q, wdata_d;
    logic                    hitFlag_q, hitFlag_d;
    logic [sizeBitLine-1:0]  fillData_q, fillData_d;
    logic [1:0]              ptr_q, ptr_d;
    logic                    cpuReady_q, cpuReady_d;
    logic                    cpuHit_q, cpuHit_d;
    logic [sizeBitLine-1:0]  cpuRdata_q, cpuRdata_d;
    logic [3:0][SETS-1:0]    valid_q;
    logic [bitsTag-1:0]      tagMem [4][SETS];

    logic [bitsDirect-1:0]   reqIndex;
    logic [bitsTag-1:0]      reqTag;
    logic [3:0]              wayHit;
    logic                    anyHit;
    logic [1:0]              hitWay;
    logic [1:0]              victimWay;
    logic                    allValid;
    logic                    fillEn;
    logic [sizeBitLine-1:0]  selDout;

    assign reqIndex  = addr_q[bitsDirect-1:0];
    assign reqTag    = addr_q[AW-1:bitsDirect];
    assign cpu_ready = cpuReady_q;
    assign cpu_hit   = cpuHit_q;
    assign cpu_rdata = cpuRdata_q;

    // Tag compare for the latched index; the lowest matching way wins, and the
    // lowest invalid way is preferred as victim before falling back to round-robin.
    always_comb begin
        wayHit    = '0;
        anyHit    = 1'b0;
        hitWay    = 2'd0;
        victimWay = ptr_q;
        allValid  = 1'b1;
        for (int w = 3; w >= 0; w--) begin
            wayHit[w] = valid_q[w][reqIndex] && (tagMem[w][reqIndex] == reqTag);
            if (wayHit[w]) begin
                anyHit = 1'b1;
                hitWay = 2'(w);
            end
            if (!valid_q[w][reqIndex]) begin
                allValid  = 1'b0;
                victimWay = 2'(w);
            end
        end
        case (hitWay)
            2'd0:    selDout = cache_dout1;
            2'd1:    selDout = cache_dout2;
            2'd2:    selDout = cache_dout3;
            default: selDout = cache_dout4;
        endcase
    end

    // Next-state and output decode; every strobe is low unless its state raises it.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        we_d         = we_q;
        wdata_d      = wdata_q;
        hitFlag_d    = hitFlag_q;
        fillData_d   = fillData_q;
        ptr_d        = ptr_q;
        cpuReady_d   = 1'b0;
        cpuHit_d     = 1'b0;
        cpuRdata_d   = cpuRdata_q;
        fillEn       = 1'b0;
        cache_we     = 4'b0000;
        cache_we_cpu = 2'b00;
        cache_we_ram = 1'b0;
        cache_re     = 1'b0;
        cache_addr   = '0;
        cache_din    = '0;
        ram_req      = 1'b0;
        ram_we       = 1'b0;
        ram_addr     = '0;
        ram_wdata    = '0;
        case (state_q)
            IDLE: begin
                if (cpu_req && gen_reset) begin
                    addr_d     = cpu_addr;
                    we_d       = cpu_we;
                    wdata_d    = cpu_wdata;
                    cache_re   = 1'b1;
                    cache_addr = cpu_addr[bitsDirect-1:0];
                    state_d    = LOOKUP;
                end
            end
            LOOKUP: begin
                cache_addr = reqIndex;
                if (we_q) begin
                    if (anyHit) begin
                        cache_we     = 4'b0001 << hitWay;
                        cache_we_cpu = 2'b01;
                        cache_din    = wdata_q;
                    end
                    hitFlag_d = anyHit;
                    state_d   = WRITE_RAM;
                end else if (anyHit) begin
                    cpuRdata_d = selDout;
                    cpuReady_d = 1'b1;
                    cpuHit_d   = 1'b1;
                    state_d    = IDLE;
                end else begin
                    state_d = REFILL;
                end
            end
            WRITE_RAM: begin
                ram_req   = 1'b1;
                ram_we    = 1'b1;
                ram_addr  = addr_q;
                ram_wdata = wdata_q;
                if (ram_ack) begin
                    cpuReady_d = 1'b1;
                    cpuHit_d   = hitFlag_q;
                    state_d    = IDLE;
                end
            end
            REFILL: begin
                ram_req  = 1'b1;
                ram_addr = addr_q;
                if (ram_ack) begin
                    fillData_d = ram_rdata;
                    state_d    = FILL;
                end
            end
            FILL: begin
                fillEn       = 1'b1;
                cache_addr   = reqIndex;
                cache_we     = 4'b0001 << victimWay;
                cache_we_ram = 1'b1;
                cache_din    = fillData_q;
                cpuRdata_d   = fillData_q;
                cpuReady_d   = 1'b1;
                if (allValid) begin
                    ptr_d = ptr_q + 2'd1;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control state, latched request, valid bits and CPU response registers.
    always_ff @(posedge clk or negedge gen_reset) begin
        if (!gen_reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            hitFlag_q  <= 1'b0;
            fillData_q <= '0;
            ptr_q      <= 2'd0;
            cpuReady_q <= 1'b0;
            cpuHit_q   <= 1'b0;
            cpuRdata_q <= '0;
            valid_q    <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            hitFlag_q  <= hitFlag_d;
            fillData_q <= fillData_d;
            ptr_q      <= ptr_d;
            cpuReady_q <= cpuReady_d;
            cpuHit_q   <= cpuHit_d;
            cpuRdata_q <= cpuRdata_d;
            if (fillEn) begin
                valid_q[victimWay][reqIndex] <= 1'b1;
            end
        end
    end

    // Tag array is plain storage; valid bits alone decide whether an entry counts.
    always_ff @(posedge clk) begin
        if (fillEn) begin
            tagMem[victimWay][reqIndex] <= reqTag;
        end
    end

endmodule

// File: tb/tb_cache_controller.sv
// tb_cache_controller: directed scenarios for cache_controller with a behavioural
// 4-way data store and a RAM responder driven from the access task.
module tb_cache_controller;

    logic        clk;
    logic        gen_reset;
    logic        cpu_req;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [63:0] cpu_wdata;
    logic        cpu_ready;
    logic        cpu_hit;
    logic [63:0] cpu_rdata;
    logic        ram_req;
    logic        ram_we;
    logic [15:0] ram_addr;
    logic [63:0] ram_wdata;
    logic        ram_ack;
    logic [63:0] ram_rdata;
    logic [3:0]  cache_we;
    logic [1:0]  cache_we_cpu;
    logic        cache_we_ram;
    logic        cache_re;
    logic [9:0]  cache_addr;
    logic [63:0] cache_din;
    logic [63:0] cache_dout1, cache_dout2, cache_dout3, cache_dout4;

    logic [63:0] dataStore [4][1024];

    int compared   = 0;
    int mismatched = 0;

    logic        obsReady, obsHit, obsRamSeen, obsRamWe, obsRamStable, obsWeRam;
    logic [63:0] obsRdata, obsRamWdata, obsDin;
    logic [15:0] obsRamAddr;
    logic [3:0]  obsWe;
    logic [1:0]  obsWeCpu;
    int          obsLatency, obsRamCycles;

    cache_controller dut (
        .clk          (clk),
        .gen_reset    (gen_reset),
        .cpu_req      (cpu_req),
        .cpu_we       (cpu_we),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_ready    (cpu_ready),
        .cpu_hit      (cpu_hit),
        .cpu_rdata    (cpu_rdata),
        .ram_req      (ram_req),
        .ram_we       (ram_we),
        .ram_addr     (ram_addr),
        .ram_wdata    (ram_wdata),
        .ram_ack      (ram_ack),
        .ram_rdata    (ram_rdata),
        .cache_we     (cache_we),
        .cache_we_cpu (cache_we_cpu),
        .cache_we_ram (cache_we_ram),
        .cache_re     (cache_re),
        .cache_addr   (cache_addr),
        .cache_din    (cache_din),
        .cache_dout1  (cache_dout1),
        .cache_dout2  (cache_dout2),
        .cache_dout3  (cache_dout3),
        .cache_dout4  (cache_dout4)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural data store: registered read the cycle after cache_re, per-way writes.
    always @(posedge clk) begin
        if (cache_re) begin
            cache_dout1 <= dataStore[0][cache_addr];
            cache_dout2 <= dataStore[1][cache_addr];
            cache_dout3 <= dataStore[2][cache_addr];
            cache_dout4 <= dataStore[3][cache_addr];
        end
        for (int w = 0; w < 4; w++) begin
            if (cache_we[w]) dataStore[w][cache_addr] <= cache_din;
        end
    end

    // Issues one CPU access and acts as RAM, recording what the controller did.
    task automatic applyStimulus(input logic we, input logic [15:0] addr, input logic [63:0] wdata,
                                 input int ackDelay, input logic [63:0] ramData, input bit pulseReq);
        bit done;
        done = 0;
        obsReady = 0; obsHit = 0; obsRdata = '0; obsRamSeen = 0; obsRamWe = 0;
        obsRamStable = 1; obsWeRam = 0; obsRamWdata = '0; obsDin = '0; obsRamAddr = '0;
        obsWe = '0; obsWeCpu = '0; obsLatency = 0; obsRamCycles = 0;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        for (int cyc = 1; cyc <= 60 && !done; cyc++) begin
            @(negedge clk);
            cpu_req = 1'b0;
            ram_ack = 1'b0;
            if (ram_req) begin
                if (!obsRamSeen) begin
                    obsRamAddr = ram_addr; obsRamWe = ram_we; obsRamWdata = ram_wdata;
                end else if (ram_addr !== obsRamAddr || ram_we !== obsRamWe || ram_wdata !== obsRamWdata) begin
                    obsRamStable = 0;
                end
                obsRamSeen = 1;
                obsRamCycles++;
                if (obsRamCycles > ackDelay) begin
                    ram_ack = 1'b1; ram_rdata = ramData;
                end else if (pulseReq && (cyc % 2 == 0)) begin
                    cpu_req = 1'b1; cpu_we = ~we; cpu_addr = addr ^ 16'h0155;
                end
            end
            obsWe    = obsWe | cache_we;
            obsWeCpu = obsWeCpu | cache_we_cpu;
            obsWeRam = obsWeRam | cache_we_ram;
            if (cache_we != 4'b0000) obsDin = cache_din;
            if (cpu_ready) begin
                obsReady = 1; obsHit = cpu_hit; obsRdata = cpu_rdata; obsLatency = cyc; done = 1;
            end
        end
        cpu_req = 1'b0;
        ram_ack = 1'b0;
    endtask

    // Pulses reset low for a few cycles and releases it on a falling edge.
    task automatic pulseReset();
        @(negedge clk);
        gen_reset = 1'b0;
        repeat (2) @(negedge clk);
        gen_reset = 1'b1;
    endtask

    task automatic test_reset();
        gen_reset = 1'b0;
        repeat (3) @(negedge clk);
        compared++; if (cpu_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_ready: got %0b expected 0", cpu_ready); end
        compared++; if (ram_req !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_ram_req: got %0b expected 0", ram_req); end
        compared++; if (cache_we !== 4'b0000) begin mismatched++; $display("[TB] FAIL reset_cache_we: got %b expected 0000", cache_we); end
        compared++; if (cpu_rdata !== 64'h0) begin mismatched++; $display("[TB] FAIL reset_rdata: got %h expected 0", cpu_rdata); end
        compared++; if (cache_re !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_cache_re: got %0b expected 0", cache_re); end
        gen_reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_read_miss();
        applyStimulus(1'b0, 16'h0040, 64'h0, 0, 64'h1122334455667788, 0);
        compared++; if (obsReady !== 1'b1) begin mismatched++; $display("[TB] FAIL miss_ready: got %0b expected 1", obsReady); end
        compared++; if (obsRamAddr !== 16'h0040 || obsRamWe !== 1'b0) begin mismatched++; $display("[TB] FAIL miss_ram: got addr %h we %0b expected 0040 we 0", obsRamAddr, obsRamWe); end
        compared++; if (obsWe !== 4'b0001 || obsWeRam !== 1'b1 || obsWeCpu !== 2'b00) begin mismatched++; $display("[TB] FAIL miss_fill_strobes: got we %b ram %0b cpu %b expected 0001 1 00", obsWe, obsWeRam, obsWeCpu); end
        compared++; if (obsRdata !== 64'h1122334455667788 || obsHit !== 1'b0) begin mismatched++; $display("[TB] FAIL miss_result: got %h hit %0b expected 1122334455667788 hit 0", obsRdata, obsHit); end
        compared++; if (obsLatency !== 4) begin mismatched++; $display("[TB] FAIL miss_latency: got %0d expected 4", obsLatency); end
    endtask

    task automatic test_read_hit();
        applyStimulus(1'b0, 16'h0040, 64'h0, 0, 64'hDEAD, 0);
        compared++; if (obsRamSeen !== 1'b0) begin mismatched++; $display("[TB] FAIL hit_no_ram: got %0b expected 0", obsRamSeen); end
        compared++; if (obsLatency !== 2 || obsHit !== 1'b1) begin mismatched++; $display("[TB] FAIL hit_timing: got lat %0d hit %0b expected 2 1", obsLatency, obsHit); end
        compared++; if (obsRdata !== 64'h1122334455667788) begin mismatched++; $display("[TB] FAIL hit_data: got %h expected 1122334455667788", obsRdata); end
    endtask

    task automatic test_write();
        applyStimulus(1'b1, 16'h0040, 64'hAA, 0, 64'h0, 0);
        compared++; if (obsWe !== 4'b0001 || obsWeCpu !== 2'b01 || obsDin !== 64'hAA) begin mismatched++; $display("[TB] FAIL whit_cache: got we %b cpu %b din %h expected 0001 01 aa", obsWe, obsWeCpu, obsDin); end
        compared++; if (obsRamWe !== 1'b1 || obsRamAddr !== 16'h0040 || obsRamWdata !== 64'hAA) begin mismatched++; $display("[TB] FAIL whit_ram: got we %0b addr %h data %h expected 1 0040 aa", obsRamWe, obsRamAddr, obsRamWdata); end
        compared++; if (obsReady !== 1'b1 || obsHit !== 1'b1 || obsLatency !== 3) begin mismatched++; $display("[TB] FAIL whit_done: got rdy %0b hit %0b lat %0d expected 1 1 3", obsReady, obsHit, obsLatency); end
        applyStimulus(1'b0, 16'h0040, 64'h0, 0, 64'hDEAD, 0);
        compared++; if (obsRdata !== 64'hAA || obsHit !== 1'b1) begin mismatched++; $display("[TB] FAIL whit_readback: got %h hit %0b expected aa 1", obsRdata, obsHit); end
        applyStimulus(1'b1, 16'h3FFF, 64'h77, 0, 64'h0, 0);
        compared++; if (obsWe !== 4'b0000 || obsWeCpu !== 2'b00) begin mismatched++; $display("[TB] FAIL wmiss_cache: got we %b cpu %b expected 0000 00", obsWe, obsWeCpu); end
        compared++; if (obsRamWe !== 1'b1 || obsRamAddr !== 16'h3FFF || obsHit !== 1'b0 || obsReady !== 1'b1) begin mismatched++; $display("[TB] FAIL wmiss_ram: got we %0b addr %h hit %0b rdy %0b expected 1 3fff 0 1", obsRamWe, obsRamAddr, obsHit, obsReady); end
        applyStimulus(1'b0, 16'h3FFF, 64'h0, 0, 64'h5555, 0);
        compared++; if (obsRamSeen !== 1'b1 || obsHit !== 1'b0) begin mismatched++; $display("[TB] FAIL wmiss_no_alloc: got ram %0b hit %0b expected 1 0", obsRamSeen, obsHit); end
    endtask

    task automatic test_replacement();
        logic [3:0] expWe [5];
        expWe[0] = 4'b0001; expWe[1] = 4'b0010; expWe[2] = 4'b0100; expWe[3] = 4'b1000; expWe[4] = 4'b0001;
        pulseReset();
        for (int t = 1; t <= 5; t++) begin
            applyStimulus(1'b0, 16'((t << 10) | 16'h0040), 64'h0, 0, 64'h1000 + 64'(t), 0);
            compared++; if (obsWe !== expWe[t-1] || obsHit !== 1'b0) begin mismatched++; $display("[TB] FAIL repl_tag%0d: got we %b hit %0b expected %b 0", t, obsWe, obsHit, expWe[t-1]); end
        end
        applyStimulus(1'b0, 16'h0440, 64'h0, 0, 64'h2001, 0);
        compared++; if (obsWe !== 4'b0010 || obsRamSeen !== 1'b1) begin mismatched++; $display("[TB] FAIL repl_pointer: got we %b ram %0b expected 0010 1", obsWe, obsRamSeen); end
        applyStimulus(1'b0, 16'h1440, 64'h0, 0, 64'hDEAD, 0);
        compared++; if (obsHit !== 1'b1 || obsRdata !== 64'h1005) begin mismatched++; $display("[TB] FAIL repl_tag5_hit: got hit %0b data %h expected 1 1005", obsHit, obsRdata); end
        applyStimulus(1'b0, 16'h0C40, 64'h0, 0, 64'hDEAD, 0);
        compared++; if (obsHit !== 1'b1 || obsRdata !== 64'h1003) begin mismatched++; $display("[TB] FAIL repl_tag3_hit: got hit %0b data %h expected 1 1003", obsHit, obsRdata); end
    endtask

    task automatic test_reset_mid_refill();
        bit seen;
        seen = 0;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0040;
        @(negedge clk);
        cpu_req = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (ram_req) seen = 1;
        end
        compared++; if (seen !== 1'b1) begin mismatched++; $display("[TB] FAIL rst_mid_reach_refill: got %0b expected 1", seen); end
        gen_reset = 1'b0;
        #1;
        compared++; if (ram_req !== 1'b0 || cpu_rdata !== 64'h0 || cpu_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_mid_outputs: got req %0b rdata %h rdy %0b expected 0 0 0", ram_req, cpu_rdata, cpu_ready); end
        repeat (2) @(negedge clk);
        gen_reset = 1'b1;
        applyStimulus(1'b0, 16'h0040, 64'h0, 0, 64'h9999, 0);
        compared++; if (obsRamSeen !== 1'b1 || obsWe !== 4'b0001 || obsRdata !== 64'h9999) begin mismatched++; $display("[TB] FAIL rst_mid_remiss: got ram %0b we %b data %h expected 1 0001 9999", obsRamSeen, obsWe, obsRdata); end
    endtask

    task automatic test_delayed_ack();
        applyStimulus(1'b0, 16'h2222, 64'h0, 10, 64'hCAFEF00D12345678, 1);
        compared++; if (obsRamCycles !== 11 || obsRamStable !== 1'b1 || obsRamAddr !== 16'h2222) begin mismatched++; $display("[TB] FAIL delay_hold: got cycles %0d stable %0b addr %h expected 11 1 2222", obsRamCycles, obsRamStable, obsRamAddr); end
        compared++; if (obsReady !== 1'b1 || obsRdata !== 64'hCAFEF00D12345678 || obsLatency !== 14) begin mismatched++; $display("[TB] FAIL delay_done: got rdy %0b data %h lat %0d expected 1 cafef00d12345678 14", obsReady, obsRdata, obsLatency); end
        repeat (2) begin
            @(negedge clk);
            compared++; if (ram_req !== 1'b0 || cpu_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL delay_ignored_req: got req %0b rdy %0b expected 0 0", ram_req, cpu_ready); end
        end
    endtask

    // Runs every scenario in order and prints the summary.
    initial begin
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        ram_ack = 1'b0; ram_rdata = '0; gen_reset = 1'b0;
        test_reset();
        test_read_miss();
        test_read_hit();
        test_write();
        test_replacement();
        test_reset_mid_refill();
        test_delayed_ack();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
